// File: rtl/aqed_pkg.sv
// Shared types and defaults for the A-QED FIFO checker: FSM state encoding,
// channel-index width helper and default parameter values.
package aqed_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int CHANNELS_DEF   = 2;
  localparam int CNT_W_DEF      = 17;
  localparam int BOUND_MULT_DEF = 4;
  localparam int BOUND_W        = 18;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ORIG_WAIT = 2'd1,
    ST_DUP_WAIT  = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  // Channel index width, never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aqed_chan_counter.sv
// Saturating up-counter with clock enable; one instance per channel per
// direction tracks how many writes/reads that channel has seen.
module aqed_chan_counter
  import aqed_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_en,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: stick at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, frozen while clk_en is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {W{1'b0}};
    end else if (clk_en) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/aqed_fifo_checker.sv
// A-QED self-consistency checker for a multi-channel FIFO: tracks one marked
// original write and its duplicate, compares their read-back data, and flags reads that never return.
module aqed_fifo_checker
  import aqed_pkg::*;
#(
  parameter int  DATA_W     = DATA_W_DEF,
  parameter int  CHANNELS   = CHANNELS_DEF,
  parameter int  CNT_W      = CNT_W_DEF,
  parameter int  BOUND_MULT = BOUND_MULT_DEF,
  localparam int CH_W       = ch_w(CHANNELS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic [15:0]       depth,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_chan,
  input  logic              exec_dup,
  output logic [DATA_W-1:0] dut_data,
  output logic              dut_wen,
  output logic [CH_W-1:0]   dut_chan,
  input  logic [DATA_W-1:0] dut_out_data,
  input  logic              dut_valid,
  input  logic [CH_W-1:0]   dut_out_chan,
  input  logic              dut_ren,
  output logic              orig_issued,
  output logic              orig_done,
  output logic              qed_done,
  output logic              qed_check,
  output logic              bound_fail
);

  logic [CHANNELS-1:0] wr_inc_s;
  logic [CHANNELS-1:0] rd_inc_s;
  logic [CNT_W-1:0]    wcnt_s [CHANNELS];
  logic [CNT_W-1:0]    rcnt_s [CHANNELS];
  logic [CNT_W-1:0]    wcnt_sel_s;
  logic [CNT_W-1:0]    rcnt_osel_s;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   o_data_q, o_data_d;
  logic [CH_W-1:0]     o_chan_q, o_chan_d;
  logic [CNT_W-1:0]    o_idx_q, o_idx_d;
  logic [CNT_W-1:0]    d_idx_q, d_idx_d;
  logic                d_vld_q, d_vld_d;
  logic [DATA_W-1:0]   o_out_q, o_out_d;
  logic                orig_done_q, orig_done_d;
  logic                qed_done_q, qed_done_d;
  logic                qed_check_q, qed_check_d;
  logic [BOUND_W-1:0]  bound_q, bound_d;
  logic                bound_fail_q, bound_fail_d;

  logic                wr_s, rd_s, rd_ochan_s;
  logic                orig_start_s, dup_match_s, orig_hit_s, dup_hit_s;
  logic [31:0]         bound_lim_s;

  assign wr_s     = clk_en & in_valid;
  assign rd_s     = clk_en & dut_ren & dut_valid;
  assign dut_data = in_data;
  assign dut_chan = in_chan;
  assign dut_wen  = wr_s;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign wr_inc_s[c] = in_valid && (in_chan == CH_W'(c));
    assign rd_inc_s[c] = dut_ren && dut_valid && (dut_out_chan == CH_W'(c));

    aqed_chan_counter #(.W(CNT_W)) u_wcnt (
      .clk    (clk),
      .reset  (reset),
      .clk_en (clk_en),
      .inc_i  (wr_inc_s[c]),
      .cnt_o  (wcnt_s[c])
    );

    aqed_chan_counter #(.W(CNT_W)) u_rcnt (
      .clk    (clk),
      .reset  (reset),
      .clk_en (clk_en),
      .inc_i  (rd_inc_s[c]),
      .cnt_o  (rcnt_s[c])
    );
  end

  // Pre-increment counts for the writing channel and the tracked channel.
  always_comb begin
    wcnt_sel_s  = {CNT_W{1'b0}};
    rcnt_osel_s = {CNT_W{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      wcnt_sel_s  = (in_chan  == CH_W'(c)) ? wcnt_s[c] : wcnt_sel_s;
      rcnt_osel_s = (o_chan_q == CH_W'(c)) ? rcnt_s[c] : rcnt_osel_s;
    end
  end

  assign orig_start_s = (state_q == ST_IDLE) && wr_s && exec_dup;
  assign dup_match_s  = ((state_q == ST_ORIG_WAIT) || (state_q == ST_DUP_WAIT)) &&
                        wr_s && exec_dup && !d_vld_q &&
                        (in_data == o_data_q) && (in_chan == o_chan_q);
  assign rd_ochan_s   = rd_s && (dut_out_chan == o_chan_q);
  assign orig_hit_s   = (state_q == ST_ORIG_WAIT) && rd_ochan_s && (rcnt_osel_s == o_idx_q);
  assign dup_hit_s    = (state_q == ST_DUP_WAIT) && rd_ochan_s && d_vld_q &&
                        (rcnt_osel_s == d_idx_q);
  assign bound_lim_s  = 32'(BOUND_MULT) * {16'd0, depth};

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = orig_start_s ? ST_ORIG_WAIT : ST_IDLE;
      ST_ORIG_WAIT: state_d = orig_hit_s   ? ST_DUP_WAIT  : ST_ORIG_WAIT;
      ST_DUP_WAIT:  state_d = dup_hit_s    ? ST_DONE      : ST_DUP_WAIT;
      ST_DONE:      state_d = ST_DONE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Captures, sticky flags and the response-bound counter.
  always_comb begin
    o_data_d     = o_data_q;
    o_chan_d     = o_chan_q;
    o_idx_d      = o_idx_q;
    d_idx_d      = d_idx_q;
    d_vld_d      = d_vld_q;
    o_out_d      = o_out_q;
    orig_done_d  = orig_done_q;
    qed_done_d   = qed_done_q;
    qed_check_d  = qed_check_q;
    bound_d      = bound_q;
    if (orig_start_s) begin
      o_data_d = in_data;
      o_chan_d = in_chan;
      o_idx_d  = wcnt_sel_s;
    end else begin
      o_data_d = o_data_q;
    end
    if (dup_match_s) begin
      d_idx_d = wcnt_sel_s;
      d_vld_d = 1'b1;
    end else begin
      d_vld_d = d_vld_q;
    end
    if (orig_hit_s) begin
      o_out_d     = dut_out_data;
      orig_done_d = 1'b1;
    end else begin
      o_out_d = o_out_q;
    end
    if (dup_hit_s) begin
      qed_done_d  = 1'b1;
      qed_check_d = (dut_out_data == o_out_q);
    end else begin
      qed_done_d = qed_done_q;
    end
    // Any-channel reads while the original is still outstanding.
    if ((state_q == ST_ORIG_WAIT) && rd_s && (bound_q != {BOUND_W{1'b1}})) begin
      bound_d = bound_q + {{(BOUND_W-1){1'b0}}, 1'b1};
    end else begin
      bound_d = bound_q;
    end
    bound_fail_d = bound_fail_q |
                   ((state_q == ST_ORIG_WAIT) && !orig_done_q &&
                    (32'(bound_d) >= bound_lim_s));
  end

  // State and capture registers; everything holds while clk_en is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      o_data_q     <= {DATA_W{1'b0}};
      o_chan_q     <= {CH_W{1'b0}};
      o_idx_q      <= {CNT_W{1'b0}};
      d_idx_q      <= {CNT_W{1'b0}};
      d_vld_q      <= 1'b0;
      o_out_q      <= {DATA_W{1'b0}};
      orig_done_q  <= 1'b0;
      qed_done_q   <= 1'b0;
      qed_check_q  <= 1'b0;
      bound_q      <= {BOUND_W{1'b0}};
      bound_fail_q <= 1'b0;
    end else if (clk_en) begin
      state_q      <= state_d;
      o_data_q     <= o_data_d;
      o_chan_q     <= o_chan_d;
      o_idx_q      <= o_idx_d;
      d_idx_q      <= d_idx_d;
      d_vld_q      <= d_vld_d;
      o_out_q      <= o_out_d;
      orig_done_q  <= orig_done_d;
      qed_done_q   <= qed_done_d;
      qed_check_q  <= qed_check_d;
      bound_q      <= bound_d;
      bound_fail_q <= bound_fail_d;
    end
  end

  // FSM outputs.
  always_comb begin
    orig_issued = 1'b0;
    case (state_q)
      ST_IDLE:      orig_issued = 1'b0;
      ST_ORIG_WAIT: orig_issued = 1'b1;
      ST_DUP_WAIT:  orig_issued = 1'b1;
      ST_DONE:      orig_issued = 1'b1;
      default:      orig_issued = 1'b0;
    endcase
  end

  assign orig_done  = orig_done_q;
  assign qed_done   = qed_done_q;
  assign qed_check  = qed_check_q;
  assign bound_fail = bound_fail_q;

endmodule
